// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - Shared opcode map, default program image and load FSM encodings.
package cpu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LD_A   = 4'h1;
  localparam logic [3:0] OP_LD_B   = 4'h2;
  localparam logic [3:0] OP_OR_A_B = 4'h3;
  localparam logic [3:0] OP_SHL_A  = 4'h4;
  localparam logic [3:0] OP_INC_A  = 4'h5;
  localparam logic [3:0] OP_OUT_A  = 4'h6;
  localparam logic [3:0] OP_JMP    = 4'h7;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] arg;
  } word_t;

  // Word 0 is the rightmost element.
  localparam word_t [7:0] DEFAULT_PROGRAM = {
    {OP_NOP,    4'h0},
    {OP_JMP,    4'h3},
    {OP_OUT_A,  4'h0},
    {OP_INC_A,  4'h0},
    {OP_SHL_A,  4'h0},
    {OP_OR_A_B, 4'h0},
    {OP_LD_B,   4'h4},
    {OP_LD_A,   4'h2}
  };

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LOAD_OP   = 2'd1;
  localparam logic [1:0] ST_LOAD_ARG  = 2'd2;
  localparam logic [1:0] ST_LOAD_DONE = 2'd3;

  function automatic word_t default_word(input int idx);
    if (idx >= 0 && idx < 8) begin
      return DEFAULT_PROGRAM[idx[2:0]];
    end
    return '0;
  endfunction

endpackage

// File: rtl/program_store_if.sv
// rtl/program_store_if.sv - CPU fetch bus: pc in, opcode/arg/cpu_hold out.
interface program_store_if #(
  parameter int ADDR_BITS = 3,
  parameter int NIBBLE    = 4
);
  logic [ADDR_BITS-1:0] pc;
  logic [NIBBLE-1:0]    opcode;
  logic [NIBBLE-1:0]    arg;
  logic                 cpu_hold;

  modport master (output pc, input opcode, input arg, input cpu_hold);
  modport slave  (input pc, output opcode, output arg, output cpu_hold);
endinterface

// File: rtl/program_store.sv
// rtl/program_store.sv - Register-file program store with front-panel nibble load mode.
module program_store
  import cpu_pkg::*;
#(
  parameter int ADDR_BITS = 3,
  parameter int NIBBLE    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  program_store_if.slave       fetch,
  input  logic                 mode_load,
  input  logic                 enter,
  input  logic [NIBBLE-1:0]    data_sw,
  output logic [ADDR_BITS-1:0] load_addr,
  output logic                 load_phase,
  output logic [NIBBLE-1:0]    echo,
  output logic                 loaded
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

  logic [NIBBLE-1:0] mem_op  [DEPTH];
  logic [NIBBLE-1:0] mem_arg [DEPTH];
  logic [1:0]        state;
  logic              enter_q;
  logic              enter_rise;

  // A held button only acts on its first cycle.
  assign enter_rise = enter & ~enter_q;

  assign fetch.opcode   = mem_op[fetch.pc];
  assign fetch.arg      = mem_arg[fetch.pc];
  assign fetch.cpu_hold = (state != ST_RUN);
  assign echo           = load_phase ? mem_arg[load_addr] : mem_op[load_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      load_addr  <= '0;
      load_phase <= 1'b0;
      loaded     <= 1'b0;
      enter_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_op[i]  <= NIBBLE'(default_word(i).opcode);
        mem_arg[i] <= NIBBLE'(default_word(i).arg);
      end
    end else begin
      enter_q <= enter;
      case (state)
        ST_RUN: begin
          if (mode_load) begin
            state      <= ST_LOAD_OP;
            load_addr  <= '0;
            load_phase <= 1'b0;
            loaded     <= 1'b0;
          end
        end
        ST_LOAD_OP: begin
          // Leaving load mode outranks a simultaneous button edge.
          if (!mode_load) begin
            state <= ST_RUN;
          end else if (enter_rise) begin
            mem_op[load_addr] <= data_sw;
            state             <= ST_LOAD_ARG;
            load_phase        <= 1'b1;
          end
        end
        ST_LOAD_ARG: begin
          if (!mode_load) begin
            state <= ST_RUN;
          end else if (enter_rise) begin
            mem_arg[load_addr] <= data_sw;
            if (load_addr == LAST_ADDR) begin
              state  <= ST_LOAD_DONE;
              loaded <= 1'b1;
            end else begin
              load_addr  <= load_addr + ADDR_ONE;
              load_phase <= 1'b0;
              state      <= ST_LOAD_OP;
            end
          end
        end
        ST_LOAD_DONE: begin
          if (!mode_load) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/program_store.md
Name: program_store

Overview:
- Upstream instruction source for the four-bit CPU core; replaces its hard-wired 8-word program.
- Holds 8 words, each a 4-bit opcode plus a 4-bit argument, in registers.
- Presents the word at the CPU's pc combinationally.
- Provides a front-panel load mode: the operator enters opcode/argument nibbles from toggle switches, one button press per nibble, while the CPU is held.

Parameters:
- ADDR_BITS, 3, program address width; depth = 2**ADDR_BITS.
- NIBBLE, 4, width of opcode, argument and switch data.

Ports:
- clk  input  1  system clock (1 MHz board clock domain).
- reset_n  input  1  asynchronous, active-low reset.
- pc  input  ADDR_BITS  CPU program counter; read address.
- mode_load  input  1  load-mode switch level, synchronous to clk.
- enter  input  1  debounced enter-button level, synchronous to clk; may stay high for many cycles.
- data_sw  input  NIBBLE  switch data written on enter.
- opcode  output  NIBBLE  opcode at address pc.
- arg  output  NIBBLE  argument at address pc.
- load_addr  output  ADDR_BITS  word currently being edited.
- load_phase  output  1  0 = editing opcode, 1 = editing argument.
- echo  output  NIBBLE  current stored value of the nibble being edited, for LEDs.
- cpu_hold  output  1  high whenever state is not RUN; the CPU must ignore step while high.
- loaded  output  1  high once all words have been entered in the current load session.

Behaviour:

Reset (asynchronous):
- Memory takes the DEFAULT_PROGRAM image.
- state = RUN, load_addr = 0, load_phase = 0, loaded = 0, enter_q = 0.

Read path:
- opcode and arg are combinational from pc in every state; there is no read latency.
- echo is combinational: mem[load_addr].opcode when load_phase = 0, otherwise mem[load_addr].arg.

Enter edge:
- enter_q is registered each cycle.
- enter_rise = enter & ~enter_q. Only enter_rise acts, so a held button produces exactly one write.

FSM states: RUN, LOAD_OP, LOAD_ARG, LOAD_DONE.
- RUN: cpu_hold = 0; enter_rise is ignored. When mode_load = 1, go to LOAD_OP, set load_addr = 0, clear loaded.
- LOAD_OP: on enter_rise, mem[load_addr].opcode <= data_sw, then go to LOAD_ARG (load_phase = 1).
- LOAD_ARG: on enter_rise, mem[load_addr].arg <= data_sw.
  - If load_addr == all-ones: go to LOAD_DONE and set loaded = 1.
  - Otherwise: load_addr increments, go to LOAD_OP.
- LOAD_DONE: enter_rise is ignored; load_addr holds at the last address.
- Any LOAD_* state: when mode_load = 0, go to RUN the same cycle. Writes already made persist. loaded keeps its value (0 if the session was aborted early).
- Priority: if mode_load = 0 and enter_rise occur in the same cycle, the mode exit wins and no write happens.
- A load_addr increment never wraps past the last address; only LOAD_DONE is reachable from it.
- Every write takes effect on the clock edge, so the new value appears on echo and on opcode/arg (when pc matches) the next cycle.
- Reset asserted mid-load restores the default image, so partial edits are lost.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode localparams (OP_LD_A, OP_LD_B, OP_OR_A_B, OP_SHL_A, OP_INC_A, ...);
  - DEFAULT_PROGRAM as 8 × {opcode, arg} constants;
  - state encodings for the FSM.
- The CPU core includes the same package.
- No sub-module is needed. The rising-edge detector is inline: one register plus one gate.

Test Plan:
1. Reset, then sweep pc 0..7 → opcode/arg equal DEFAULT_PROGRAM (pc 0 gives OP_LD_A/4'b0010, pc 1 gives OP_LD_B/4'b0100); cpu_hold = 0, loaded = 0.
2. mode_load = 1, then 16 enter pulses with data_sw = 4'h1, 4'h2, ..., 4'hF, 4'h0 → mem[k] = {2k+1, 2k+2} mod 16; after the 16th pulse state = LOAD_DONE and loaded = 1; a 17th pulse changes nothing; mode_load = 0 → cpu_hold = 0 and the pc sweep reads the new image.
3. In LOAD_OP with load_addr = 0, hold enter high for 50 cycles with data_sw = 4'hA → exactly one write; opcode[0] = 4'hA; load_phase = 1; echo shows the old arg[0].
4. Enter 3 words, then drop mode_load while enter rises in the same cycle with data_sw = 4'h5 → no write; state = RUN; loaded = 0; words 0..2 are new and words 3..7 keep the default.
5. In RUN, enter pulses with data_sw = 4'hF → memory unchanged and cpu_hold stays 0.
6. Assert reset_n = 0 asynchronously in LOAD_ARG at load_addr = 4 → outputs reset immediately without waiting for clk; memory returns to DEFAULT_PROGRAM; state = RUN.
